// File: rtl/multiply_axis_exerciser.sv
// Traffic generator and checker for the multiply kernel's AXI-Stream ports:
// streams operands on A/B, checks C against A*B, and flags a stall when traffic stops.
module multiply_axis_exerciser #(
  parameter int DATA_W    = 32,
  parameter int NUM_BEATS = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] A_TDATA,
  output logic              A_TVALID,
  input  logic              A_TREADY,
  output logic [DATA_W-1:0] B_TDATA,
  output logic              B_TVALID,
  input  logic              B_TREADY,
  input  logic [DATA_W-1:0] C_TDATA,
  input  logic              C_TVALID,
  output logic              C_TREADY,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic              stall,
  output logic [2:0]        stall_ports
);

  localparam int CW = $clog2(NUM_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BEATS     = CW'(NUM_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);
  localparam logic [TW-1:0] WD_LIMIT  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       a_cnt_r;
  logic [CW-1:0]       b_cnt_r;
  logic [CW-1:0]       c_cnt_r;
  logic [TW-1:0]       wd_cnt_r;
  logic                run_s;
  logic                a_hs_s;
  logic                b_hs_s;
  logic                c_hs_s;
  logic                any_hs_s;
  logic                mismatch_s;
  logic                last_c_s;
  logic                timeout_s;
  logic [2*DATA_W-1:0] expect_s;
  logic [15:0]         err_next_s;

  // Stream qualifiers decode from state and registered counters only
  assign run_s    = (state_r == ST_RUN);
  assign A_TVALID = run_s && (a_cnt_r < BEATS);
  assign B_TVALID = run_s && (b_cnt_r < BEATS);
  assign C_TREADY = run_s && (c_cnt_r < BEATS);

  // Handshake decode, expected product and saturating error update
  always_comb begin
    a_hs_s     = A_TVALID && A_TREADY;
    b_hs_s     = B_TVALID && B_TREADY;
    c_hs_s     = C_TVALID && C_TREADY;
    any_hs_s   = a_hs_s || b_hs_s || c_hs_s;
    // Full-width product so the truncation matches the kernel's modular result
    expect_s   = ((2*DATA_W)'(c_cnt_r) + (2*DATA_W)'(1)) *
                 ((2*DATA_W)'(c_cnt_r) + (2*DATA_W)'(2));
    mismatch_s = (C_TDATA != expect_s[DATA_W-1:0]);
    last_c_s   = c_hs_s && (c_cnt_r == LAST_BEAT);
    timeout_s  = !any_hs_s && (wd_cnt_r == WD_LIMIT);
    if (c_hs_s && mismatch_s && (err_count != 16'hFFFF)) begin
      err_next_s = err_count + 16'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Run-control FSM with beat counters, watchdog and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      a_cnt_r     <= '0;
      b_cnt_r     <= '0;
      c_cnt_r     <= '0;
      wd_cnt_r    <= '0;
      A_TDATA     <= DATA_W'(1);
      B_TDATA     <= DATA_W'(2);
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      stall       <= 1'b0;
      err_count   <= 16'd0;
      stall_ports <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r     <= ST_RUN;
            a_cnt_r     <= '0;
            b_cnt_r     <= '0;
            c_cnt_r     <= '0;
            wd_cnt_r    <= '0;
            A_TDATA     <= DATA_W'(1);
            B_TDATA     <= DATA_W'(2);
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= 16'd0;
            stall_ports <= 3'b000;
          end
        end
        ST_RUN: begin
          // TDATA tracks count+offset so it only moves on a completed handshake
          if (a_hs_s) begin
            a_cnt_r <= a_cnt_r + CW'(1);
            A_TDATA <= DATA_W'(a_cnt_r) + DATA_W'(2);
          end
          if (b_hs_s) begin
            b_cnt_r <= b_cnt_r + CW'(1);
            B_TDATA <= DATA_W'(b_cnt_r) + DATA_W'(3);
          end
          if (c_hs_s) begin
            c_cnt_r <= c_cnt_r + CW'(1);
          end
          err_count <= err_next_s;
          if (any_hs_s) begin
            wd_cnt_r <= '0;
          end else begin
            wd_cnt_r <= wd_cnt_r + TW'(1);
          end
          if (last_c_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == 16'd0);
          end else if (timeout_s) begin
            state_r     <= ST_STALL;
            busy        <= 1'b0;
            stall       <= 1'b1;
            stall_ports <= {C_TREADY & ~C_TVALID, B_TVALID & ~B_TREADY, A_TVALID & ~A_TREADY};
          end
        end
        ST_STALL: begin
          state_r <= ST_STALL;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
